// File: rtl/mastermind_pkg.sv
// Shared Mastermind definitions: code geometry, empty color, scorer FSM encodings.
// Used by the scorer and the game core.
package mastermind_pkg;

    localparam int COLOR_W  = 3;
    localparam int NUM_POS  = 4;
    localparam int CODE_W   = COLOR_W * NUM_POS;
    localparam int CNT_W    = 3;
    localparam int IDX_W    = 2;

    localparam logic [COLOR_W-1:0] COLOR_EMPTY = 3'd0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXACT = 2'd1;
    localparam logic [1:0] ST_COLOR = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Position p occupies bits [3p+2:3p].
    function automatic logic [COLOR_W-1:0] get_color(input logic [CODE_W-1:0] code,
                                                     input logic [IDX_W-1:0] pos);
        return code[COLOR_W*pos +: COLOR_W];
    endfunction

endpackage

// File: rtl/mastermind_match_find.sv
// Finds the lowest answer position that is still unused and holds the requested color.
// Purely combinational; the caller decides whether the color is worth searching for.
module mastermind_match_find
    import mastermind_pkg::*;
(
    input  logic [COLOR_W-1:0] color,
    input  logic [CODE_W-1:0]  answer,
    input  logic [NUM_POS-1:0] used,
    output logic               found,
    output logic [NUM_POS-1:0] match_oh
);

    always_comb begin
        found    = 1'b0;
        match_oh = '0;
        for (int j = 0; j < NUM_POS; j++) begin
            if (!found && !used[j] && (answer[COLOR_W*j +: COLOR_W] == color)) begin
                found       = 1'b1;
                match_oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mastermind_scorer.sv
// Scores a guess against a secret code: exact pass then color pass, one position per cycle.
// Fixed latency: done pulses in the 9th cycle after start is sampled.
module mastermind_scorer
    import mastermind_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [11:0]       guess,
    input  logic [11:0]       answer,
    output logic              busy,
    output logic              done,
    output logic [2:0]        exact_cnt,
    output logic [2:0]        color_cnt,
    output logic              win,
    output logic [1:0]        fsm_state
);

    // Handshake: start is sampled only in IDLE (ignored otherwise); busy covers the
    // whole operation; done is a one-cycle pulse and the result outputs hold until the next done.

    logic [1:0]         state;
    logic [CODE_W-1:0]  g_reg;
    logic [CODE_W-1:0]  a_reg;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   exact_r;
    logic [CNT_W-1:0]   color_r;
    logic [NUM_POS-1:0] g_used;
    logic [NUM_POS-1:0] a_used;

    logic [COLOR_W-1:0] cur_g;
    logic [COLOR_W-1:0] cur_a;
    logic               mf_found;
    logic [NUM_POS-1:0] mf_oh;
    logic               exact_hit;
    logic               color_hit;
    logic [CNT_W-1:0]   color_next;

    assign cur_g      = get_color(g_reg, idx);
    assign cur_a      = get_color(a_reg, idx);
    assign exact_hit  = (cur_g == cur_a) && (cur_g != COLOR_EMPTY);
    assign color_hit  = !g_used[idx] && (cur_g != COLOR_EMPTY) && mf_found;
    assign color_next = color_r + {2'b00, color_hit};

    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    mastermind_match_find u_match_find (
        .color    (cur_g),
        .answer   (a_reg),
        .used     (a_used),
        .found    (mf_found),
        .match_oh (mf_oh)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            g_reg     <= '0;
            a_reg     <= '0;
            idx       <= '0;
            exact_r   <= '0;
            color_r   <= '0;
            g_used    <= '0;
            a_used    <= '0;
            done      <= 1'b0;
            exact_cnt <= '0;
            color_cnt <= '0;
            win       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        g_reg   <= guess;
                        a_reg   <= answer;
                        exact_r <= '0;
                        color_r <= '0;
                        g_used  <= '0;
                        a_used  <= '0;
                        idx     <= '0;
                        state   <= ST_EXACT;
                    end
                end
                ST_EXACT: begin
                    if (exact_hit) begin
                        exact_r     <= exact_r + 3'd1;
                        g_used[idx] <= 1'b1;
                        a_used[idx] <= 1'b1;
                    end
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) state <= ST_COLOR;
                end
                ST_COLOR: begin
                    if (color_hit) begin
                        color_r <= color_next;
                        a_used  <= a_used | mf_oh;
                    end
                    idx <= idx + 2'd1;
                    // The last color step also publishes the result, so done lines up with DONE.
                    if (idx == 2'd3) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        exact_cnt <= exact_r;
                        color_cnt <= color_next;
                        win       <= (exact_r == 3'd4);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
